// File: rtl/ver_encoder_if.sv
// Request/response stream bundle for ver_encoder.
// Slave side is the encoder; master side is the producer/consumer.
interface ver_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_illegal;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7,
    output in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_word, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7,
    input  in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_word, out_illegal
  );
endinterface

// File: rtl/ver_encoder.sv
// RV32I field-to-word encoder with legality check and output FIFO.
// Define VER_ENCODER_M_EXT_EN to accept OP funct7=0000001 (M family).
module ver_encoder #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  ver_encoder_if.slave           bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_WIDTH-1:0]   word_count,
  output logic [CNT_WIDTH-1:0]   err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  assign op  = bus.in_opcode;
  assign f3  = bus.in_funct3;
  assign f7  = bus.in_funct7;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign imm = bus.in_imm;

  logic [31:0] r_word, i_word, sh_word, s_word;
  logic [31:0] b_word, u_word, j_word;

  assign r_word  = {f7, rs2, rs1, f3, rd, op};
  assign i_word  = {imm[11:0], rs1, f3, rd, op};
  assign sh_word = {f7, imm[4:0], rs1, f3, rd, op};
  assign s_word  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  assign b_word  = {imm[12], imm[10:5], rs2, rs1, f3,
                    imm[4:1], imm[11], op};
  assign u_word  = {imm[31:12], rd, op};
  assign j_word  = {imm[20], imm[10:1], imm[11],
                    imm[19:12], rd, op};

  // Range checks: upper bits must be a pure sign extension.
  logic i_ok, b_ok, j_ok, u_ok, is_sh, sh_ok, m_ok, op_ok;

  assign i_ok  = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign u_ok  = ~(|imm[11:0]);
  assign is_sh = (f3 == 3'b001) | (f3 == 3'b101);
  assign sh_ok = ~(|imm[31:5]) &
                 ((f7 == 7'h00) |
                  ((f7 == 7'h20) & (f3 == 3'b101)));
`ifdef VER_ENCODER_M_EXT_EN
  assign m_ok  = (f7 == 7'h01);
`else
  assign m_ok  = 1'b0;
`endif
  assign op_ok = (f7 == 7'h00) | m_ok |
                 ((f7 == 7'h20) &
                  ((f3 == 3'b000) | (f3 == 3'b101)));

  logic [31:0] enc;
  logic        legal;

  always_comb begin
    enc   = '0;
    legal = 1'b0;
    unique case (op)
      OP_OP: begin
        enc   = r_word;
        legal = op_ok;
      end
      OP_IMM: begin
        enc   = is_sh ? sh_word : i_word;
        legal = is_sh ? sh_ok : i_ok;
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        enc   = i_word;
        legal = i_ok;
      end
      OP_STORE: begin
        enc   = s_word;
        legal = i_ok;
      end
      OP_BRANCH: begin
        enc   = b_word;
        legal = b_ok;
      end
      OP_LUI, OP_AUIPC: begin
        enc   = u_word;
        legal = u_ok;
      end
      OP_JAL: begin
        enc   = j_word;
        legal = j_ok;
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  logic [32:0]          mem_q [DEPTH];
  logic [AW-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]          level_q, level_d;
  logic [CNT_WIDTH-1:0] wc_q, wc_d, ec_q, ec_d;
  logic                 push, pop;
  logic [32:0]          head;

  assign bus.in_ready  = level_q < (AW+1)'(DEPTH);
  assign bus.out_valid = level_q != '0;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  assign head = mem_q[rptr_q];

  assign bus.out_word    = bus.out_valid ? head[31:0] : NOP;
  assign bus.out_illegal = bus.out_valid & head[32];
  assign level      = level_q;
  assign word_count = wc_q;
  assign err_count  = ec_q;

  // Storage needs no reset: entries are only read below level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= legal ? {1'b0, enc} : {1'b1, NOP};
  end

  always_comb begin
    rptr_d  = rptr_q + AW'(pop);
    wptr_d  = wptr_q + AW'(push);
    level_d = level_q;
    if (push & ~pop) level_d = level_q + 1'b1;
    if (pop & ~push) level_d = level_q - 1'b1;
    wc_d = wc_q;
    ec_d = ec_q;
    if (push & ~(&wc_q)) wc_d = wc_q + 1'b1;
    if (push & ~legal & ~(&ec_q)) ec_d = ec_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      level_q <= '0;
      wc_q    <= '0;
      ec_q    <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      level_q <= level_d;
      wc_q    <= wc_d;
      ec_q    <= ec_d;
    end
  end
endmodule

// File: tb/tb_ver_encoder.sv
// Random + directed bench for ver_encoder against a queue model.
// Narrow counters so saturation is reached within the run.
module tb_ver_encoder;
  localparam int DEPTH = 4;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0]    level;
  logic [CW-1:0] word_count, err_count;

  ver_encoder_if bus ();

  ver_encoder #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .level      (level),
    .word_count (word_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_enc(
    input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [31:0] imm);
    int s;
    logic ok;
    logic [31:0] w, base;
    s = imm;
    ok = 1'b0;
    w = '0;
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (op)
      7'h33: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
`ifdef VER_ENCODER_M_EXT_EN
        ok = ok || (f7 == 1);
`endif
        w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
      end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          ok = (imm < 32) && (f7 == 0 || (f7 == 7'h20 && f3 == 5));
          w = ((32'(f7) * 32 + (imm & 31)) << 20) | base | (32'(rd) << 7);
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w = ((imm & 32'hfff) << 20) | base | (32'(rd) << 7);
        end
      end
      7'h03, 7'h67, 7'h73: begin
        ok = (s >= -2048) && (s <= 2047);
        w = ((imm & 32'hfff) << 20) | base | (32'(rd) << 7);
      end
      7'h23: begin
        ok = (s >= -2048) && (s <= 2047);
        w = (((imm >> 5) & 127) << 25) | (32'(rs2) << 20) | base |
            ((imm & 31) << 7);
      end
      7'h63: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) |
            (32'(rs2) << 20) | base | (((imm >> 1) & 15) << 8) |
            (((imm >> 11) & 1) << 7);
      end
      7'h37, 7'h17: begin
        ok = (imm & 32'hfff) == 0;
        w = (imm & 32'hfffff000) | (32'(rd) << 7) | 32'(op);
      end
      7'h6f: begin
        ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) |
            (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) |
            (32'(rd) << 7) | 32'(op);
      end
      default: ok = 1'b0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'h13};
  endfunction

  logic [32:0] q[$];
  int mwc = 0;
  int mec = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      mwc = 0;
      mec = 0;
    end else begin
      logic acc, pp;
      logic [32:0] e;
      acc = bus.in_valid && (q.size() < DEPTH);
      pp  = bus.out_ready && (q.size() > 0);
      if (pp) void'(q.pop_front());
      if (acc) begin
        e = ref_enc(bus.in_opcode, bus.in_funct3, bus.in_funct7,
                    bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
        q.push_back(e);
        if (mwc < CMAX) mwc++;
        if (e[32] && mec < CMAX) mec++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("m_valid", bus.out_valid, q.size() != 0);
      check("m_level", level, q.size());
      check("m_ready", bus.in_ready, q.size() < DEPTH);
      check("m_word", bus.out_word, q.size() ? q[0][31:0] : 32'h13);
      check("m_ill", bus.out_illegal, q.size() ? q[0][32] : 1'b0);
      check("m_wcnt", word_count, mwc);
      check("m_ecnt", err_count, mec);
    end
  end

  task automatic set_req(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    bus.in_opcode = op;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
  endtask

  task automatic req(input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] imm);
    @(posedge clk);
    #1;
    set_req(op, f3, f7, rd, rs1, rs2, imm);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic rand_req();
    logic [6:0] ops [10];
    logic [6:0] op, f7;
    logic [31:0] imm;
    int k;
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
            7'h37, 7'h63, 7'h67, 7'h6f, 7'h73};
    k = $urandom_range(0, 10);
    op = (k == 10) ? 7'($urandom) : ops[k];
    case ($urandom_range(0, 5))
      0: imm = 32'($urandom_range(0, 64)) - 32'd32;
      1: imm = $urandom;
      2: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
      3: imm = 32'($urandom) << 12;
      4: imm = 32'($urandom_range(0, 2200000)) - 32'd1100000;
      default: imm = 32'($urandom_range(0, 63));
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    set_req(op, 3'($urandom), f7, 5'($urandom),
            5'($urandom), 5'($urandom), imm);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_req('0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_ready", bus.in_ready, 1'b1);
    check("rst_word", bus.out_word, 32'h13);
    check("rst_ill", bus.out_illegal, 1'b0);
    check("rst_level", level, 0);
    check("rst_cnt", {word_count, err_count}, 0);

    req(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    check("addi", {bus.out_illegal, bus.out_word}, {1'b0, 32'h00500093});
    req(7'h13, 3'd5, 7'h20, 5'd3, 5'd4, 5'd0, 32'd3);
    check("srai", {bus.out_illegal, bus.out_word}, {1'b0, 32'h40325193});
    req(7'h37, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'h12345000);
    check("lui", {bus.out_illegal, bus.out_word}, {1'b0, 32'h12345137});
    req(7'h6f, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, -32'sd4);
    check("jal", {bus.out_illegal, bus.out_word}, {1'b0, 32'hFFDFF06F});
    req(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3);
    check("bodd", {bus.out_illegal, bus.out_word}, {1'b1, 32'h13});
    check("bodd_err", err_count, 1);
    req(7'h33, 3'd0, 7'h01, 5'd5, 5'd6, 5'd7, 32'd0);
`ifdef VER_ENCODER_M_EXT_EN
    check("mul", {bus.out_illegal, bus.out_word}, {1'b0, 32'h027302B3});
`else
    check("mul", {bus.out_illegal, bus.out_word}, {1'b1, 32'h13});
`endif

    // Fill past capacity, then drain in order.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'(i + 1));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("full_level", level, 4);
    check("full_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain", bus.out_word, (32'(i + 1) << 20) | 32'h93);
      @(posedge clk);
      #1;
    end
    check("drain_empty", bus.out_valid, 1'b0);

    // Async reset with three entries queued.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("pre_level", level, 3);
    reset = 1'b1;
    #1;
    check("ar_level", level, 0);
    check("ar_valid", bus.out_valid, 1'b0);
    check("ar_cnt", {word_count, err_count}, 0);
    check("ar_word", bus.out_word, 32'h13);
    @(posedge clk);
    #1;
    check("ar_noacc", {level, word_count}, 0);
    bus.in_valid = 1'b0;
    reset = 1'b0;

    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      rand_req();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = (c % 50 < 10) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    check("sat_wcnt", word_count, CMAX);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ver_encoder.md
VER_ENCODER -- requirements
Module: ver_encoder

Interface
REQ-001 Parameter DEPTH, default 4: output FIFO entries; SHALL be a power of two, >= 2.
REQ-002 Parameter CNT_WIDTH, default 16: width of the encoded-word and error counters.
REQ-003 Port clk  input  1: single clock, all state on rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port in_valid  input  1: request present.
REQ-006 Port in_ready  output  1: request accepted when in_valid && in_ready at a rising edge.
REQ-007 Ports in_opcode 7, in_funct3 3, in_funct7 7, in_rd 5, in_rs1 5, in_rs2 5 (all input): instruction fields.
REQ-008 Port in_imm  input  32: signed immediate/offset; for shifts, shamt in bits 4:0.
REQ-009 Port out_valid  output  1: FIFO head valid.
REQ-010 Port out_ready  input  1: head consumed when out_valid && out_ready.
REQ-011 Port out_word  output  32: encoded RV32 instruction word.
REQ-012 Port out_illegal  output  1: head request was illegal.
REQ-013 Port level  output  $clog2(DEPTH)+1: FIFO occupancy.
REQ-014 Ports word_count, err_count  output  CNT_WIDTH: accepted requests, illegal requests.

Function
REQ-015 Encoding SHALL be the standard RV32I R/I/S/B/U/J layout selected by in_opcode: OP=R, STORE=S, BRANCH=B, LUI/AUIPC=U, JAL=J, LOAD/OP_IMM/JALR/SYSTEM=I.
REQ-016 OP_IMM with funct3 001/101: imm field = {in_funct7, in_imm[4:0]}.
REQ-017 Illegal request: unknown opcode; I/S imm outside [-2048,2047]; B imm outside [-4096,4094] or odd; J imm outside [-2^20,2^20-2] or odd; U imm[11:0] != 0; shift in_imm[31:5] != 0; funct7 not in {0000000, 0100000} for OP/shift-imm; 0100000 with OP funct3 other than 000/101, or shift-imm funct3 001.
REQ-018 Illegal requests SHALL be queued with out_word = 0x00000013 (NOP) and out_illegal = 1; legal ones with out_illegal = 0.
REQ-019 Encoding and legality SHALL be computed combinationally from in_* and written into the FIFO tail on accept.
REQ-020 in_ready = (level < DEPTH); no full-FIFO bypass, so a pop does not raise in_ready in the same cycle.
REQ-021 out_valid = (level != 0); out_word/out_illegal driven from the head entry.
REQ-022 Latency: a request accepted at edge N SHALL be visible on out_* after edge N when FIFO was empty.
REQ-023 Simultaneous push and pop: level unchanged; order strictly FIFO.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH.
REQ-025 word_count increments per accept; err_count per illegal accept; both saturate at all-ones.
REQ-026 out_word/out_illegal SHALL remain stable while out_valid && !out_ready.

Reset
REQ-027 Reset SHALL clear pointers, level, word_count, err_count; out_valid = 0, in_ready = 1, out_word = 0x00000013, out_illegal = 0.
REQ-028 Reset asserted mid-transfer SHALL discard all queued entries immediately; no accept occurs while reset is high.

Configuration
REQ-029 Macro VER_ENCODER_M_EXT_EN defined: OP with funct7 0000001 (any funct3) is legal and encoded as R-type (MUL/DIV family).
REQ-030 Macro undefined: OP with funct7 0000001 is illegal per REQ-018.

Verification
REQ-031 addi x1,x0,5 (OP_IMM, f3 000, rd 1, imm 5) -> out_word 0x00500093, out_illegal 0, one cycle later.
REQ-032 srai x3,x4,3 (f3 101, f7 0100000) -> 0x40325193; lui x2 imm 0x12345000 -> 0x12345137; jal x0 imm -4 -> 0xFFDFF06F.
REQ-033 BRANCH imm 3 -> 0x00000013, out_illegal 1, err_count +1.
REQ-034 OP f7 0000001 rd5 rs1 6 rs2 7: with macro -> 0x027302B3 legal; without -> NOP, illegal.
REQ-035 DEPTH=4, out_ready 0, 6 requests -> 4 accepted, in_ready 0, level 4; release out_ready -> 4 words in order, pointers wrap.
REQ-036 Reset asserted with level 3 -> level 0, out_valid 0, counters 0 asynchronously.
